// File: rtl/mxm_x_feeder_pkg.sv
// Shared sizing and FSM encoding for the MXM read-side X feeder.
// P and LW follow the project-wide systolic array height and MXM word width.
package mxm_x_feeder_pkg;

  localparam int MXM_P  = 16;
  localparam int MXM_LW = 16;
  localparam int MXM_CW = 24;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } feed_state_e;

endpackage

// File: rtl/mxm_skew_lane.sv
// One skew lane: DEPTH-stage shift register of {vld, last, data} that
// advances only on en and clears asynchronously.
module mxm_skew_lane #(
  parameter int DEPTH = 1,
  parameter int LW    = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          vld_i,
  input  logic          last_i,
  input  logic [LW-1:0] data_i,
  output logic          vld_o,
  output logic          last_o,
  output logic [LW-1:0] data_o
);

  logic [DEPTH-1:0]         vld_q;
  logic [DEPTH-1:0]         last_q;
  logic [DEPTH-1:0][LW-1:0] data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      last_q <= '0;
      data_q <= '0;
    end else if (en) begin
      vld_q[0]  <= vld_i;
      last_q[0] <= last_i;
      data_q[0] <= data_i;
      for (int k = 1; k < DEPTH; k++) begin
        vld_q[k]  <= vld_q[k-1];
        last_q[k] <= last_q[k-1];
        data_q[k] <= data_q[k-1];
      end
    end
  end

  assign vld_o  = vld_q[DEPTH-1];
  assign last_o = last_q[DEPTH-1];
  assign data_o = data_q[DEPTH-1];

endmodule

// File: rtl/mxm_x_feeder.sv
// Pops N vectors from the MXM FIFO per job and feeds them to the systolic
// array X inputs with lane i delayed i cycles; whole pipe stalls on x_rdy=0.
//
// state   | meaning
// ST_IDLE | waiting for start_pulse; rem/popped hold last job's values
// ST_RUN  | popping and draining; leaves in the cycle done is high
module mxm_x_feeder
  import mxm_x_feeder_pkg::*;
#(
  parameter int P  = MXM_P,
  parameter int LW = MXM_LW,
  parameter int CW = MXM_CW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_pulse,
  input  logic [CW-1:0]   n_vec_minus_1,
  output logic            busy,
  output logic            done,
  output logic            mxm_rd_en,
  input  logic [P*LW-1:0] mxm_dout,
  input  logic            mxm_empty,
  output logic [P-1:0]    x_vld,
  output logic [P-1:0]    x_last,
  output logic [P*LW-1:0] x_data,
  input  logic            x_rdy
);

  feed_state_e   state_q, state_d;
  logic [CW-1:0] rem_q, rem_d;
  logic [CW-1:0] popped_q, popped_d;
  logic          drained_q, drained_d;
  logic          done_q, done_d;
  logic          en;
  logic          in_run;
  logic          last_pop;

  assign en     = x_rdy;
  assign in_run = (state_q == ST_RUN);

  // drained_q guards the full-scale count, where popped would wrap to zero.
  assign mxm_rd_en = in_run & ~mxm_empty & x_rdy & ~drained_q & (popped_q <= rem_q);
  assign last_pop  = mxm_rd_en & (popped_q == rem_q);

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    popped_d  = popped_q;
    drained_d = drained_q;
    done_d    = in_run & x_vld[P-1] & x_last[P-1] & x_rdy;
    case (state_q)
      ST_IDLE: begin
        if (start_pulse) begin
          state_d   = ST_RUN;
          rem_d     = n_vec_minus_1;
          popped_d  = '0;
          drained_d = 1'b0;
        end
      end
      ST_RUN: begin
        if (mxm_rd_en) popped_d = popped_q + CW'(1);
        if (last_pop) drained_d = 1'b1;
        if (done_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      rem_q     <= '0;
      popped_q  <= '0;
      drained_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      popped_q  <= popped_d;
      drained_q <= drained_d;
      done_q    <= done_d;
    end
  end

  assign busy = in_run;
  assign done = done_q;

  for (genvar i = 0; i < P; i++) begin : g_lane
    logic [LW-1:0] lane_in;
    assign lane_in = mxm_rd_en ? mxm_dout[i*LW +: LW] : '0;

    mxm_skew_lane #(
      .DEPTH(i + 1),
      .LW   (LW)
    ) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .vld_i (mxm_rd_en),
      .last_i(last_pop),
      .data_i(lane_in),
      .vld_o (x_vld[i]),
      .last_o(x_last[i]),
      .data_o(x_data[i*LW +: LW])
    );
  end

endmodule

// File: tb/tb_mxm_x_feeder.sv
// Scoreboard bench for mxm_x_feeder: expected pops, lane outputs and done
// are derived from the x_rdy / empty schedule of each job.
module tb_mxm_x_feeder;
  localparam int TP = 16;
  localparam int LW = 16;
  localparam int CW = 24;
  localparam int SL = 1024;

  logic            clk = 1'b0;
  logic            rst_n, start_pulse, busy, done, mxm_rd_en, mxm_empty, x_rdy;
  logic [CW-1:0]   n_vec_minus_1;
  logic [TP*LW-1:0] mxm_dout, x_data;
  logic [TP-1:0]   x_vld, x_last;

  typedef struct {
    int            cyc;
    bit            last;
    logic [LW-1:0] data;
  } exp_t;

  exp_t             lane_q [TP][$];
  int               exp_pop[$];
  int               exp_done[$];
  logic [TP*LW-1:0] fifo[$];
  bit               rdy_s[SL];
  bit               emp_s[SL];
  bit               force_empty, pop_seen;
  int               cyc, total, bad;

  logic [TP-1:0]    pv, pl;
  logic [TP*LW-1:0] pd;
  bit               prev_valid, prev_rdy, prev_done;

  mxm_x_feeder dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_pulse  (start_pulse),
    .n_vec_minus_1(n_vec_minus_1),
    .busy         (busy),
    .done         (done),
    .mxm_rd_en    (mxm_rd_en),
    .mxm_dout     (mxm_dout),
    .mxm_empty    (mxm_empty),
    .x_vld        (x_vld),
    .x_last       (x_last),
    .x_data       (x_data),
    .x_rdy        (x_rdy)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog act=%0d req=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  function automatic void check(bit ok, string nm, logic [255:0] act, logic [255:0] req);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s cyc=%0d act=%0h req=%0h", nm, cyc, act, req);
    end
  endfunction

  function automatic void refresh();
    mxm_dout  = (fifo.size() > 0) ? fifo[0] : '0;
    mxm_empty = force_empty || (fifo.size() == 0);
  endfunction

  function automatic logic [TP*LW-1:0] rand_word();
    logic [TP*LW-1:0] w;
    for (int i = 0; i < TP; i++) w[i*LW +: LW] = LW'($urandom_range(0, 65535));
    return w;
  endfunction

  // cycle of the n-th x_rdy=1 cycle strictly after cycle c
  function automatic int nth_rdy_after(int c, int n);
    int k = c;
    int cnt = 0;
    while (cnt < n && k < SL - 1) begin
      k++;
      if (rdy_s[k]) cnt++;
    end
    return k;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (pop_seen && fifo.size() > 0) void'(fifo.pop_front());
    cyc++;
    refresh();
  endtask

  task automatic set_idle();
    start_pulse = 1'b0;
    x_rdy = 1'b1;
    force_empty = 1'b0;
    refresh();
  endtask

  task automatic sched_clean();
    for (int k = 0; k < SL; k++) begin
      rdy_s[k] = 1'b1;
      emp_s[k] = 1'b0;
    end
  endtask

  task automatic sched_rand();
    for (int k = 0; k < SL; k++) begin
      rdy_s[k] = ($urandom_range(0, 99) < 85);
      emp_s[k] = ($urandom_range(0, 99) < 15);
    end
  endtask

  task automatic run_job(int n, int busy_k, bit start_in_done, int rst_k);
    int   pk[$];
    int   k, base, done_off, size0;
    exp_t e;
    while (fifo.size() < n + 2) fifo.push_back(rand_word());
    size0 = fifo.size();
    base  = cyc;
    k = 0;
    while (pk.size() < n && k < SL - 1) begin
      k++;
      if (rdy_s[k] && !emp_s[k]) pk.push_back(k);
    end
    for (int j = 0; j < n; j++) begin
      for (int i = 0; i < TP; i++) begin
        e.cyc  = base + nth_rdy_after(pk[j], i + 1);
        e.last = (j == n - 1);
        e.data = fifo[j][i*LW +: LW];
        lane_q[i].push_back(e);
      end
      exp_pop.push_back(base + pk[j]);
    end
    done_off = nth_rdy_after(pk[n-1], TP) + 1;
    exp_done.push_back(base + done_off);

    start_pulse   = 1'b1;
    n_vec_minus_1 = CW'(n - 1);
    x_rdy         = rdy_s[0];
    force_empty   = emp_s[0];
    refresh();
    for (k = 1; k <= done_off + 3 && k < SL; k++) begin
      tick();
      start_pulse   = (k == busy_k) || (start_in_done && k == done_off);
      n_vec_minus_1 = CW'($urandom_range(0, 40));
      x_rdy         = rdy_s[k];
      force_empty   = emp_s[k];
      refresh();
      if (k == rst_k) break;
    end
    if (rst_k > 0) begin
      #1 rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      set_idle();
      repeat (4) tick();
      check(fifo.size() == size0 - (rst_k - 1), "rst_pop_count", fifo.size(), size0 - (rst_k - 1));
    end else begin
      set_idle();
      tick();
      check(fifo.size() == size0 - n, "pop_count", fifo.size(), size0 - n);
      check(exp_done.size() == 0, "missing_done", exp_done.size(), 0);
      check(exp_pop.size() == 0, "missing_pop", exp_pop.size(), 0);
      for (int i = 0; i < TP; i++)
        check(lane_q[i].size() == 0, "missing_lane_vec", lane_q[i].size(), 0);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      check(!busy && !done && !mxm_rd_en && x_vld == '0 && x_last == '0 && x_data == '0,
            "reset_zero", {busy, done, mxm_rd_en, x_vld, x_last}, 0);
      for (int i = 0; i < TP; i++) lane_q[i].delete();
      exp_pop.delete();
      exp_done.delete();
      pop_seen   = 1'b0;
      prev_valid = 1'b0;
      prev_done  = 1'b0;
    end else begin
      bit   bub_ok;
      int   ep;
      exp_t e;
      pop_seen = mxm_rd_en;
      if (mxm_rd_en) begin
        check(x_rdy && !mxm_empty, "pop_rule", {x_rdy, mxm_empty}, 2'b10);
        if (exp_pop.size() == 0) check(1'b0, "extra_pop", cyc, 0);
        else begin
          ep = exp_pop.pop_front();
          check(cyc == ep, "pop_cycle", cyc, ep);
        end
      end
      bub_ok = 1'b1;
      for (int i = 0; i < TP; i++) begin
        if (x_vld[i] && x_rdy) begin
          if (lane_q[i].size() == 0) check(1'b0, "extra_vld", i, 0);
          else begin
            e = lane_q[i].pop_front();
            check(cyc == e.cyc, "lane_time", {i[15:0], cyc[31:0]}, {i[15:0], e.cyc[31:0]});
            check(x_data[i*LW +: LW] == e.data && x_last[i] == e.last, "lane_data",
                  {x_last[i], x_data[i*LW +: LW]}, {e.last, e.data});
          end
        end else if (!x_vld[i]) begin
          if (x_data[i*LW +: LW] != '0 || x_last[i]) bub_ok = 1'b0;
        end
      end
      check(bub_ok, "bubble_zero", x_data, 0);
      if (prev_valid && !prev_rdy)
        check(x_vld == pv && x_last == pl && x_data == pd, "stall_hold", x_data, pd);
      if (done) begin
        check(busy, "busy_at_done", busy, 1);
        if (exp_done.size() == 0) check(1'b0, "extra_done", cyc, 0);
        else begin
          ep = exp_done.pop_front();
          check(cyc == ep, "done_cycle", cyc, ep);
        end
      end
      if (prev_done) check(!busy, "busy_after_done", busy, 0);
      pv = x_vld;
      pl = x_last;
      pd = x_data;
      prev_rdy   = x_rdy;
      prev_valid = 1'b1;
      prev_done  = done;
    end
  end

  initial begin
    rst_n = 1'b0;
    start_pulse = 1'b0;
    n_vec_minus_1 = '0;
    x_rdy = 1'b1;
    force_empty = 1'b0;
    pop_seen = 1'b0;
    cyc = 0;
    total = 0;
    bad = 0;
    refresh();
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();

    sched_clean();                                     run_job(3, 0, 1'b0, 0);
    sched_clean(); rdy_s[3] = 0; rdy_s[4] = 0;         run_job(3, 0, 1'b0, 0);
    sched_clean(); emp_s[2] = 1; emp_s[3] = 1; emp_s[4] = 1; run_job(4, 0, 1'b0, 0);
    sched_clean();                                     run_job(5, 3, 1'b1, 0);
    sched_clean();                                     run_job(8, 0, 1'b0, 2);
    sched_clean();                                     run_job(1, 0, 1'b0, 0);
    repeat (10) begin
      sched_rand();
      run_job(int'($urandom_range(1, 24)), ($urandom_range(0, 2) == 0) ? 4 : 0,
              1'($urandom_range(0, 1)), 0);
    end
    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
